camera_buffer_ctrl: RTL and testbench
=====================================

// Module: camera_buffer_ctrl
// PURPOSE
//  Parametrised camera-station controller: power/filming state machine plus a
//  saturating buffer-occupancy counter. Configurable capacity, ready threshold,
//  and fill/download/flush step sizes. Adds stop-filming and done-pulse behaviour.
//  Sits between station command inputs and the display/status logic.
// PARAMETERS
//  CNT_W      8    occupancy counter width; CAPACITY < 2**CNT_W (elaboration $error otherwise)
//  CAPACITY   100  buffer full level
//  READY_LVL  80   level at which a download may be requested; 0 < READY_LVL <= CAPACITY
//  FILL_STEP  1    increment per cycle while filming
//  DL_STEP    1    decrement per cycle while downloading
//  FLUSH_STEP 4    decrement per cycle while flushing
//  LOW_LVL    40   low-water mark for the drain_low flag
// PORTS
//  clk          in   1      clock
//  reset        in   1      synchronous, active-high
//  standby_req  in   1      LOW_POWER -> STANDBY
//  film_req     in   1      STANDBY -> ACTIVE
//  stop_req     in   1      end filming early
//  download_req in   1      request download
//  flush_req    in   1      request flush (lower priority than download_req)
//  state        out  3      encoded state, see below
//  fill         out  CNT_W  buffer occupancy
//  filming      out  1      state in {ACTIVE, ACTIVE_RDY, DL_PEND}
//  ready_to_dl  out  1      state in {ACTIVE_RDY, IDLE}
//  full         out  1      fill == CAPACITY
//  drain_low    out  1      state in {DOWNLOAD, FLUSH} and fill <= LOW_LVL
//  done         out  1      one-cycle pulse on the DOWNLOAD/FLUSH -> LOW_POWER edge
// BEHAVIOUR
//  Reset: state=LOW_POWER, fill=0, done=0; all other outputs derive from these (0).
//  States: 0 LOW_POWER, 1 STANDBY, 2 ACTIVE, 3 ACTIVE_RDY, 4 DL_PEND, 5 IDLE,
//          6 DOWNLOAD, 7 FLUSH.
//  All transitions and counter updates occur on the same posedge. Decisions use
//  the registered fill value, which gives one cycle of lag.
//  Transitions (unlisted conditions hold state):
//   LOW_POWER : standby_req -> STANDBY
//   STANDBY   : film_req -> ACTIVE
//   ACTIVE    : stop_req -> IDLE; else fill >= READY_LVL -> ACTIVE_RDY
//   ACTIVE_RDY: stop_req -> IDLE; else download_req -> DL_PEND;
//               else fill == CAPACITY -> IDLE
//   DL_PEND   : stop_req or fill == CAPACITY -> DOWNLOAD
//   IDLE      : download_req -> DOWNLOAD; else flush_req -> FLUSH
//   DOWNLOAD  : fill == 0 -> LOW_POWER, with done=1 for that one cycle
//   FLUSH     : fill == 0 -> LOW_POWER, with done=1 for that one cycle
//  Counter:
//   - filming states: fill <= min(fill + FILL_STEP, CAPACITY)
//   - DOWNLOAD: fill <= max(fill - DL_STEP, 0)
//   - FLUSH: fill <= max(fill - FLUSH_STEP, 0)
//   - all other states: hold
//   - Arithmetic is done at CNT_W+1 bits; fill never wraps.
//  Simultaneous requests: stop_req beats download_req; download_req beats flush_req.
//  Requests not valid in the current state are ignored.
//  Reset mid-operation (any state) forces LOW_POWER and fill=0 next edge; no done pulse.
//  IDLE out of STOP with fill < READY_LVL: ready_to_dl still 1 (IDLE).
// TESTING
//  1 reset 3 cycles; standby_req 1 cyc; film_req 1 cyc -> state 1 then 2, fill=0;
//    fill 80 after 80 active cycles, state=3 next edge, ready_to_dl=1.
//  2 Continue with no requests -> fill saturates at 100 (full=1), state=5,
//    fill holds 100 for 50 idle cycles.
//  3 From IDLE, download_req+flush_req same cycle -> state=6; after 100 cycles
//    fill=0; next edge state=0 with done=1 exactly one cycle; drain_low rises at fill=40.
//  4 From IDLE (fill=100), flush_req -> state=7; fill steps 96,92..0 (25 cyc);
//    state=0, done pulse.
//  5 Pulse download_req at fill=85 -> state=4, fill keeps rising;
//    at fill=100 -> state=6.
//    Repeat, and assert stop_req at fill=90 -> state=6 with fill=90.
//  6 stop_req at fill=30 in ACTIVE -> IDLE, fill=30. Reset asserted mid-DOWNLOAD ->
//    state=0, fill=0, done=0. Param set CAPACITY=200, CNT_W=8, FILL_STEP=3 ->
//    fill clamps at 200, no wrap.

Source files
------------

// File: rtl/camera_buffer_ctrl_if.sv
// ---------------------------------------------------------------------------
// camera_buffer_ctrl_if
// Groups the station command requests and the status outputs of the camera
// buffer controller into one bundle.
//   master : drives the five request lines, observes the status lines
//   slave  : the controller itself (receives requests, drives status)
// Signals:
//   standby_req, film_req, stop_req, download_req, flush_req : requests
//   state[2:0]    encoded controller state
//   fill[CNT_W-1:0] buffer occupancy
//   filming, ready_to_dl, full, drain_low, done : status flags
// ---------------------------------------------------------------------------
interface camera_buffer_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             standby_req;
    logic             film_req;
    logic             stop_req;
    logic             download_req;
    logic             flush_req;
    logic [2:0]       state;
    logic [CNT_W-1:0] fill;
    logic             filming;
    logic             ready_to_dl;
    logic             full;
    logic             drain_low;
    logic             done;

    modport master (
        output standby_req, film_req, stop_req, download_req, flush_req,
        input  state, fill, filming, ready_to_dl, full, drain_low, done
    );

    modport slave (
        input  standby_req, film_req, stop_req, download_req, flush_req,
        output state, fill, filming, ready_to_dl, full, drain_low, done
    );
endinterface

// File: rtl/camera_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// camera_buffer_ctrl
// Camera-station controller: a power/filming state machine plus a saturating
// buffer-occupancy counter that fills while filming and drains while a
// download or flush is in progress.
// Ports:
//   clk    : clock
//   reset  : synchronous, active-high; returns to LOW_POWER with an empty buffer
//   bus    : camera_buffer_ctrl_if.slave (requests in, state/fill/flags out)
// Parameters:
//   CNT_W, CAPACITY, READY_LVL, FILL_STEP, DL_STEP, FLUSH_STEP, LOW_LVL
// ---------------------------------------------------------------------------
module camera_buffer_ctrl #(
    parameter int CNT_W      = 8,
    parameter int CAPACITY   = 100,
    parameter int READY_LVL  = 80,
    parameter int FILL_STEP  = 1,
    parameter int DL_STEP    = 1,
    parameter int FLUSH_STEP = 4,
    parameter int LOW_LVL    = 40
) (
    input logic                  clk,
    input logic                  reset,
    camera_buffer_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        LOW_POWER  = 3'd0,
        STANDBY    = 3'd1,
        ACTIVE     = 3'd2,
        ACTIVE_RDY = 3'd3,
        DL_PEND    = 3'd4,
        IDLE       = 3'd5,
        DOWNLOAD   = 3'd6,
        FLUSH      = 3'd7
    } state_t;

    // Catch parameter sets the counter cannot represent before anything runs.
    if (CAPACITY >= (1 << CNT_W)) begin : g_cap_check
        $error("camera_buffer_ctrl: CAPACITY must be below 2**CNT_W");
    end
    if (READY_LVL <= 0 || READY_LVL > CAPACITY) begin : g_ready_check
        $error("camera_buffer_ctrl: READY_LVL must be in 1..CAPACITY");
    end

    // All level arithmetic is one bit wider than the counter so that adding
    // a step near the top never wraps before the clamp is applied.
    localparam logic [CNT_W:0] CAP_X   = (CNT_W+1)'(CAPACITY);
    localparam logic [CNT_W:0] READY_X = (CNT_W+1)'(READY_LVL);
    localparam logic [CNT_W:0] LOW_X   = (CNT_W+1)'(LOW_LVL);
    localparam logic [CNT_W:0] FILL_X  = (CNT_W+1)'(FILL_STEP);
    localparam logic [CNT_W:0] DL_X    = (CNT_W+1)'(DL_STEP);
    localparam logic [CNT_W:0] FLUSH_X = (CNT_W+1)'(FLUSH_STEP);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] fill_q, fill_d;
    logic             done_q, done_d;

    logic [CNT_W:0]   fillExt;
    logic [CNT_W:0]   fillSum;
    logic [CNT_W:0]   fillNext;
    logic             atCapacity;
    logic             isEmpty;

    assign fillExt    = {1'b0, fill_q};
    assign atCapacity = (fillExt == CAP_X);
    assign isEmpty    = (fill_q == '0);

    // State register, occupancy counter and the done pulse all move on the
    // same edge; reset wins over everything and never produces a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOW_POWER;
            fill_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic. Decisions look at the registered fill, so a level is
    // acted on one cycle after it appears. Priority inside each state is
    // stop_req, then download_req, then flush_req.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            LOW_POWER: begin
                if (bus.standby_req) state_d = STANDBY;
            end
            STANDBY: begin
                if (bus.film_req) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (bus.stop_req)            state_d = IDLE;
                else if (fillExt >= READY_X) state_d = ACTIVE_RDY;
            end
            ACTIVE_RDY: begin
                if (bus.stop_req)          state_d = IDLE;
                else if (bus.download_req) state_d = DL_PEND;
                else if (atCapacity)       state_d = IDLE;
            end
            DL_PEND: begin
                if (bus.stop_req || atCapacity) state_d = DOWNLOAD;
            end
            IDLE: begin
                if (bus.download_req)   state_d = DOWNLOAD;
                else if (bus.flush_req) state_d = FLUSH;
            end
            DOWNLOAD, FLUSH: begin
                if (isEmpty) begin
                    state_d = LOW_POWER;
                    done_d  = 1'b1;
                end
            end
            default: state_d = LOW_POWER;
        endcase
    end

    // Occupancy update driven by the current state: fill while filming,
    // drain while downloading or flushing, hold otherwise. Both directions
    // saturate instead of wrapping.
    always_comb begin
        fillSum  = fillExt + FILL_X;
        fillNext = fillExt;
        case (state_q)
            ACTIVE, ACTIVE_RDY, DL_PEND: begin
                fillNext = (fillSum > CAP_X) ? CAP_X : fillSum;
            end
            DOWNLOAD: begin
                fillNext = (fillExt < DL_X) ? '0 : (fillExt - DL_X);
            end
            FLUSH: begin
                fillNext = (fillExt < FLUSH_X) ? '0 : (fillExt - FLUSH_X);
            end
            default: fillNext = fillExt;
        endcase
        fill_d = fillNext[CNT_W-1:0];
    end

    assign bus.state       = state_q;
    assign bus.fill        = fill_q;
    assign bus.done        = done_q;
    assign bus.full        = atCapacity;
    assign bus.filming     = (state_q == ACTIVE) || (state_q == ACTIVE_RDY) ||
                             (state_q == DL_PEND);
    assign bus.ready_to_dl = (state_q == ACTIVE_RDY) || (state_q == IDLE);
    assign bus.drain_low   = ((state_q == DOWNLOAD) || (state_q == FLUSH)) &&
                             (fillExt <= LOW_X);

endmodule

// File: tb/tb_camera_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_camera_buffer_ctrl
// Directed bench for camera_buffer_ctrl. Expected state transitions are
// queued when the stimulus that causes them is issued; a monitor pops and
// compares one entry every time the DUT changes state or pulses done.
// Level checks between transitions go through checkOutput. A second
// instance with CAPACITY=200, FILL_STEP=3 exercises the clamp near the top
// of an 8-bit counter.
// ---------------------------------------------------------------------------
module tb_camera_buffer_ctrl;

    localparam logic [4:0] REQ_STANDBY = 5'b10000;
    localparam logic [4:0] REQ_FILM    = 5'b01000;
    localparam logic [4:0] REQ_STOP    = 5'b00100;
    localparam logic [4:0] REQ_DL      = 5'b00010;
    localparam logic [4:0] REQ_FLUSH   = 5'b00001;

    logic clk;
    logic reset;

    camera_buffer_ctrl_if #(.CNT_W(8)) bus  ();
    camera_buffer_ctrl_if #(.CNT_W(8)) bus2 ();

    camera_buffer_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    camera_buffer_ctrl #(
        .CNT_W     (8),
        .CAPACITY  (200),
        .FILL_STEP (3)
    ) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    typedef struct {
        string      name;
        logic [2:0] st;
        logic [7:0] fill;
        logic       done;
    } expRec_t;

    expRec_t expQ[$];
    int      checkCount = 0;
    int      passCount  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Status flags as the interface defines them for the default instance
    // (CAPACITY=100, LOW_LVL=40): {filming, ready_to_dl, full, drain_low}.
    function automatic logic [3:0] specFlags(input logic [2:0] st, input logic [7:0] fill);
        logic filming, rdy, full, drain;
        filming = (st == 3'd2) || (st == 3'd3) || (st == 3'd4);
        rdy     = (st == 3'd3) || (st == 3'd5);
        full    = (fill == 8'd100);
        drain   = ((st == 3'd6) || (st == 3'd7)) && (fill <= 8'd40);
        return {filming, rdy, full, drain};
    endfunction

    task automatic pushExp(input string name, input logic [2:0] st,
                           input logic [7:0] fill, input logic done);
        expRec_t r;
        r.name = name;
        r.st   = st;
        r.fill = fill;
        r.done = done;
        expQ.push_back(r);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [4:0] req);
        {bus.standby_req, bus.film_req, bus.stop_req, bus.download_req, bus.flush_req} = req;
        tick(1);
        {bus.standby_req, bus.film_req, bus.stop_req, bus.download_req, bus.flush_req} = 5'b0;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // One scoreboard comparison against the oldest queued expectation.
    task automatic compareFront();
        expRec_t    r;
        logic [15:0] act, exp;
        checkCount++;
        act = {bus.state, bus.fill, bus.filming, bus.ready_to_dl, bus.full,
               bus.drain_low, bus.done};
        if (expQ.size() == 0) begin
            $display("[TB] FAIL unexpected_event: got state=%0d fill=%0d done=%0b, expected no event",
                     bus.state, bus.fill, bus.done);
        end else begin
            r   = expQ.pop_front();
            exp = {r.st, r.fill, specFlags(r.st, r.fill), r.done};
            if (act === exp) passCount++;
            else $display("[TB] FAIL %s: got {st,fill,flags,done}=%h, expected %h",
                          r.name, act, exp);
        end
    endtask

    // Monitor: the first sample under reset checks the reset state; after
    // that every state change or done pulse consumes one expectation.
    initial begin
        logic [2:0] prevState;
        bit         primed;
        primed    = 1'b0;
        prevState = 3'd0;
        forever begin
            @(negedge clk);
            if (!primed) begin
                if (reset) begin
                    compareFront();
                    primed    = 1'b1;
                    prevState = bus.state;
                end
            end else if (bus.state != prevState || bus.done) begin
                compareFront();
                prevState = bus.state;
            end
        end
    end

    task automatic startFilming();
        pushExp("to_standby", 3'd1, 8'd0, 1'b0);
        applyStimulus(REQ_STANDBY);
        pushExp("to_active", 3'd2, 8'd0, 1'b0);
        applyStimulus(REQ_FILM);
    endtask

    // Film from empty all the way into IDLE at capacity (101 edges).
    task automatic fillToIdle();
        startFilming();
        pushExp("to_active_rdy", 3'd3, 8'd81, 1'b0);
        pushExp("full_to_idle", 3'd5, 8'd100, 1'b0);
        tick(101);
    endtask

    initial begin
        reset = 1'b1;
        {bus.standby_req, bus.film_req, bus.stop_req, bus.download_req, bus.flush_req} = 5'b0;
        {bus2.standby_req, bus2.film_req, bus2.stop_req, bus2.download_req, bus2.flush_req} = 5'b0;
        pushExp("reset", 3'd0, 8'd0, 1'b0);
        tick(3);
        reset = 1'b0;

        // Power up, film to the ready level, then on to full and IDLE.
        startFilming();
        pushExp("to_active_rdy", 3'd3, 8'd81, 1'b0);
        pushExp("full_to_idle", 3'd5, 8'd100, 1'b0);
        tick(80);
        checkOutput("fill_after_80", bus.fill, 80);
        checkOutput("state_at_80", bus.state, 2);
        tick(20);
        checkOutput("full_in_active_rdy", bus.full, 1);
        tick(1);
        tick(50);
        checkOutput("idle_hold_fill", bus.fill, 100);
        checkOutput("idle_hold_state", bus.state, 5);

        // Download beats flush; drain_low rises at 40; done pulse at the end.
        pushExp("dl_over_flush", 3'd6, 8'd100, 1'b0);
        applyStimulus(REQ_DL | REQ_FLUSH);
        tick(59);
        checkOutput("drain_low_at_41", bus.drain_low, 0);
        tick(1);
        checkOutput("drain_low_at_40", bus.drain_low, 1);
        tick(40);
        checkOutput("dl_empty_fill", bus.fill, 0);
        checkOutput("dl_empty_state", bus.state, 6);
        pushExp("dl_done", 3'd0, 8'd0, 1'b1);
        tick(1);
        tick(1);
        checkOutput("dl_done_one_cycle", bus.done, 0);

        // Flush from full: steps of 4 over 25 edges.
        fillToIdle();
        pushExp("to_flush", 3'd7, 8'd100, 1'b0);
        applyStimulus(REQ_FLUSH);
        tick(1);
        checkOutput("flush_96", bus.fill, 96);
        tick(1);
        checkOutput("flush_92", bus.fill, 92);
        tick(23);
        checkOutput("flush_empty", bus.fill, 0);
        pushExp("flush_done", 3'd0, 8'd0, 1'b1);
        tick(2);

        // Download requested at 85 keeps filming until full.
        startFilming();
        pushExp("to_active_rdy", 3'd3, 8'd81, 1'b0);
        tick(85);
        pushExp("to_dl_pend", 3'd4, 8'd86, 1'b0);
        applyStimulus(REQ_DL);
        pushExp("pend_full_to_dl", 3'd6, 8'd100, 1'b0);
        tick(14);
        checkOutput("dl_pend_fill_100", bus.fill, 100);
        tick(1);
        pushExp("pend_dl_done", 3'd0, 8'd0, 1'b1);
        tick(101);

        // Same again, but stop at 89 so the download starts at 90.
        startFilming();
        pushExp("to_active_rdy", 3'd3, 8'd81, 1'b0);
        tick(85);
        pushExp("to_dl_pend", 3'd4, 8'd86, 1'b0);
        applyStimulus(REQ_DL);
        tick(3);
        pushExp("stop_to_dl", 3'd6, 8'd90, 1'b0);
        applyStimulus(REQ_STOP);
        pushExp("stop_dl_done", 3'd0, 8'd0, 1'b1);
        tick(91);

        // Early stop into IDLE below the ready level, then reset mid-download.
        startFilming();
        tick(29);
        pushExp("stop_to_idle", 3'd5, 8'd30, 1'b0);
        applyStimulus(REQ_STOP);
        checkOutput("stop_idle_ready", bus.ready_to_dl, 1);
        pushExp("idle_to_dl", 3'd6, 8'd30, 1'b0);
        applyStimulus(REQ_DL);
        tick(10);
        checkOutput("dl_fill_20", bus.fill, 20);
        pushExp("reset_mid_dl", 3'd0, 8'd0, 1'b0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
        checkOutput("post_reset_done", bus.done, 0);

        // Wide-step instance: 3 per cycle must clamp at 200, not wrap.
        bus2.standby_req = 1'b1;
        tick(1);
        bus2.standby_req = 1'b0;
        bus2.film_req = 1'b1;
        tick(1);
        bus2.film_req = 1'b0;
        checkOutput("p2_state_active", bus2.state, 2);
        tick(66);
        checkOutput("p2_fill_198", bus2.fill, 198);
        tick(1);
        checkOutput("p2_fill_clamp", bus2.fill, 200);
        checkOutput("p2_full", bus2.full, 1);
        tick(10);
        checkOutput("p2_fill_hold", bus2.fill, 200);
        checkOutput("p2_state_idle", bus2.state, 5);

        tick(2);
        checkOutput("scoreboard_drained", expQ.size(), 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
